// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: single-grant round-robin arbiter for an AXI crossbar.
// Grants one master->slave transaction at a time and holds it from the
// address phase until the read/write completes or the watchdog fires.
// Requests aimed at a non-existent slave are never granted and are flagged
// on decerr instead.
module axi_rr_arbiter #(
    parameter int NUM_M   = 4,
    parameter int NUM_S   = 3,
    parameter int TGT_W   = 4,
    parameter int TIMEOUT = 256,
    parameter int MW      = $clog2(NUM_M),
    parameter int SW      = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NUM_M-1:0]         req_valid,
    input  logic [NUM_M-1:0]         req_write,
    input  logic [NUM_M*TGT_W-1:0]   req_target,
    input  logic [NUM_S-1:0]         s_addr_ready,
    input  logic [NUM_S-1:0]         s_rd_done,
    input  logic [NUM_S-1:0]         s_wr_done,
    output logic                     gnt_valid,
    output logic [MW-1:0]            gnt_m,
    output logic [SW-1:0]            gnt_s,
    output logic                     gnt_write,
    output logic [NUM_M-1:0]         gnt_onehot,
    output logic                     timeout,
    output logic                     abort,
    output logic [NUM_M-1:0]         decerr
);

    localparam int          CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned NM = NUM_M;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Registered grant and bookkeeping
    logic [MW-1:0]    ptr;
    logic [MW-1:0]    gnt_m_q;
    logic [SW-1:0]    gnt_s_q;
    logic             gnt_write_q;
    logic [CW-1:0]    wdog;
    logic             timeout_q;
    logic             abort_q;
    logic [NUM_M-1:0] decerr_q;

    // Per-master decode
    logic [TGT_W-1:0] tgt [NUM_M];
    logic [NUM_M-1:0] elig;
    logic [NUM_M-1:0] oor;

    // Arbitration result
    logic             win_found;
    logic [MW-1:0]    win_m;
    logic [SW-1:0]    win_s;
    logic             win_write;

    // FSM decision terms
    logic             done;
    logic             expire;
    logic             abort_set;
    logic             timeout_set;
    logic             release_grant;

    // Split the packed targets and classify each request as eligible or out of range
    always_comb begin
        elig = '0;
        oor  = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            tgt[i] = req_target[i*TGT_W +: TGT_W];
            if (32'(tgt[i]) < 32'(NUM_S)) begin
                elig[i] = req_valid[i];
            end else begin
                oor[i] = req_valid[i];
            end
        end
    end

    // Rotating search starting just after the last-granted master
    always_comb begin
        logic [MW-1:0] idx;
        win_found = 1'b0;
        win_m     = '0;
        win_s     = '0;
        win_write = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NM; k++) begin
            idx = MW'((32'(ptr) + k) % NM);
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_m     = idx;
                win_s     = SW'(tgt[idx]);
                win_write = req_write[idx];
            end
        end
    end

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: address handshake/abort, completion and watchdog expiry
    always_comb begin
        state_nxt     = state;
        abort_set     = 1'b0;
        timeout_set   = 1'b0;
        release_grant = 1'b0;
        done          = gnt_write_q ? s_wr_done[gnt_s_q] : s_rd_done[gnt_s_q];
        expire        = (TIMEOUT != 0) && (wdog == CW'(TIMEOUT - 1));
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (!req_valid[gnt_m_q]) begin
                    state_nxt = IDLE;
                    abort_set = 1'b1;
                end else if (s_addr_ready[gnt_s_q]) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                // Completion in the expiry cycle takes priority over the watchdog
                if (done) begin
                    state_nxt     = IDLE;
                    release_grant = 1'b1;
                end else if (expire) begin
                    state_nxt     = IDLE;
                    timeout_set   = 1'b1;
                    release_grant = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant capture, pointer update, watchdog counter and registered pulses
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ptr         <= MW'(NUM_M - 1);
            gnt_m_q     <= '0;
            gnt_s_q     <= '0;
            gnt_write_q <= 1'b0;
            wdog        <= '0;
            timeout_q   <= 1'b0;
            abort_q     <= 1'b0;
            decerr_q    <= '0;
        end else begin
            decerr_q  <= oor;
            abort_q   <= abort_set;
            timeout_q <= timeout_set;

            if (state == IDLE && win_found) begin
                gnt_m_q     <= win_m;
                gnt_s_q     <= win_s;
                gnt_write_q <= win_write;
            end else if (state_nxt == IDLE) begin
                gnt_m_q     <= '0;
                gnt_s_q     <= '0;
                gnt_write_q <= 1'b0;
            end

            // An aborted grant leaves the pointer alone so that master keeps its turn
            if (release_grant) begin
                ptr <= gnt_m_q;
            end

            if (state == DATA && state_nxt == DATA) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
        end
    end

    // Output decode from registered state
    always_comb begin
        gnt_valid  = (state != IDLE);
        gnt_m      = gnt_m_q;
        gnt_s      = gnt_s_q;
        gnt_write  = gnt_write_q;
        gnt_onehot = '0;
        if (state != IDLE) begin
            gnt_onehot[gnt_m_q] = 1'b1;
        end
        timeout    = timeout_q;
        abort      = abort_q;
        decerr     = decerr_q;
    end

endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
Parametrised single-grant AXI interconnect arbiter. It arbitrates NUM_M masters' read/write requests onto NUM_S slaves and holds each grant from address phase through transaction completion.
Arbitration is rotating round-robin, with a registered grant and a per-transaction watchdog. Out-of-range targets are rejected.
It sits beside the crossbar muxes; gnt_m/gnt_s/gnt_write steer the address, data and response channels.

Parameters:
NUM_M, 4, number of masters (>=2)
NUM_S, 3, number of slaves (>=1)
TGT_W, 4, width of each master's target slave index
TIMEOUT, 256, max cycles in DATA state before forced release; 0 disables the watchdog
MW, $clog2(NUM_M), derived; master index width
SW, $clog2(NUM_S) (min 1), derived; slave index width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
req_valid  in  NUM_M  per-master ARVALID|AWVALID
req_write  in  NUM_M  1 = master's pending request is a write (AW), 0 = read (AR)
req_target  in  NUM_M*TGT_W  packed per-master target slave index; master i at [i*TGT_W +: TGT_W]
s_addr_ready  in  NUM_S  per-slave ARREADY|AWREADY
s_rd_done  in  NUM_S  per-slave RVALID&RREADY&RLAST
s_wr_done  in  NUM_S  per-slave BVALID&BREADY
gnt_valid  out  1  grant active
gnt_m  out  MW  granted master index
gnt_s  out  SW  granted slave index
gnt_write  out  1  granted transaction is a write
gnt_onehot  out  NUM_M  one-hot copy of gnt_m, all zero when gnt_valid=0
timeout  out  1  one-cycle pulse on watchdog expiry
abort  out  1  one-cycle pulse when a granted master drops req_valid before the address handshake
decerr  out  NUM_M  registered per master: 1 while req_valid=1 and req_target>=NUM_S

Behaviour:
- Reset (async, ARESET=1):
  - state=IDLE; all outputs 0.
  - last-grant pointer = NUM_M-1, so M0 has first priority.
  - watchdog counter = 0.
- Eligibility: master i is eligible when req_valid[i]=1 and req_target_i < NUM_S. Slave ready is NOT required for eligibility.
- Ineligible out-of-range requests are never granted; decerr[i] is registered each cycle from the eligibility inputs.
- State machine:
  - IDLE: search masters (ptr+1) mod NUM_M, (ptr+2) mod NUM_M, ..., wrapping; the first eligible master wins.
    - On a winner: next cycle state=ADDR, with gnt_m/gnt_s/gnt_write/gnt_onehot registered from the winner and gnt_valid=1.
    - Grant latency: 1 cycle from request to gnt_valid.
    - No winner: stay in IDLE, outputs 0.
  - ADDR: wait for the address handshake, req_valid[gnt_m] & s_addr_ready[gnt_s]; next cycle state=DATA.
    - If req_valid[gnt_m]=0: pulse abort, go to IDLE, clear the grant; the pointer is NOT updated.
    - s_rd_done/s_wr_done are ignored in ADDR.
  - DATA: completion is s_wr_done[gnt_s] when gnt_write=1, else s_rd_done[gnt_s]. Done of the opposite type or from another slave is ignored.
    - On completion: next cycle IDLE, grant outputs 0, pointer = gnt_m.
    - The earliest re-grant is one cycle after that (IDLE is always visited for 1 cycle).
- Watchdog:
  - Counter clears on entry to DATA and increments each DATA cycle without completion.
  - When the counter reaches TIMEOUT-1 without completion: pulse timeout, go to IDLE, pointer = gnt_m.
  - Completion in the expiry cycle wins; timeout stays 0.
  - TIMEOUT=0: counter never expires.
- Simultaneous requests: exactly one grant, per the round-robin order. The losing master keeps its request and wins the next arbitration if it is still eligible.
- req_target/req_write are sampled only in the IDLE winning cycle; later changes do not affect the grant.
- Reset asserted mid-ADDR/DATA: immediate return to reset values. No pulse outputs.
- Single outstanding transaction system-wide; no pipelining across grants.

Test Plan:
- Reset, then M2 req_valid, read, target 1 -> cycle+1 gnt_valid=1, gnt_m=2, gnt_s=1, gnt_write=0, gnt_onehot=4'b0100. s_addr_ready[1]=1 -> DATA. s_rd_done[1] -> IDLE, then all grant outputs 0.
- All four masters request continuously, each target 0, immediate ready/done -> grant order M0,M1,M2,M3,M0; each grant cycle separated by at least one IDLE cycle.
- M1 write target 2 in DATA; pulse s_rd_done[2] and s_wr_done[0] -> no release. Then s_wr_done[2] -> IDLE next cycle.
- M0 target 5 and M3 target 0 both valid -> decerr=4'b0001 one cycle later; M3 granted, M0 never granted.
- TIMEOUT=8, M1 read in DATA, no done -> timeout pulses exactly once, 8 DATA cycles after DATA entry; IDLE follows, next winner search starts at M2.
- M2 granted, drops req_valid in ADDR -> abort pulse, IDLE. M2 re-requests with M3 also requesting -> M2 granted (pointer unchanged). ARESET pulsed during DATA -> all outputs 0 asynchronously.
